// File: rtl/systolic_array_rect.sv
// Weight-stationary ROWS x COLS systolic array: internal input skew / output deskew,
// double-buffered weights switched per vector, optional saturating accumulation, row/column masks.
module systolic_array_rect #(
  parameter int ROWS             = 16,
  parameter int COLS             = 16,
  parameter int DATA_WIDTH_IN    = 8,
  parameter int DATA_WIDTH_ACCUM = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic                                    in_switch,
  input  logic [ROWS-1:0][DATA_WIDTH_IN-1:0]      in_data,
  input  logic [COLS-1:0][DATA_WIDTH_ACCUM-1:0]   acc_in,
  input  logic                                    w_valid,
  output logic                                    w_ready,
  input  logic [$clog2(ROWS)-1:0]                 w_row_idx,
  input  logic [COLS-1:0][DATA_WIDTH_IN-1:0]      w_data,
  output logic                                    w_drop,
  input  logic                                    cfg_valid,
  input  logic [ROWS-1:0]                         cfg_row_en,
  input  logic [COLS-1:0]                         cfg_col_en,
  input  logic                                    cfg_sat,
  output logic                                    cfg_err,
  output logic                                    busy,
  output logic                                    out_valid,
  output logic [COLS-1:0][DATA_WIDTH_ACCUM-1:0]   out_data
);
  localparam int DW = DATA_WIDTH_IN;
  localparam int AW = DATA_WIDTH_ACCUM;
  localparam int L  = ROWS + COLS - 1;
  localparam int SW = ROWS + COLS - 2;
  localparam int CW = $clog2(ROWS + COLS);
  localparam int IW = $clog2(ROWS);
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  // One PE step: psum + sext(x*w), clamped on signed overflow when sat is set.
  function automatic logic [AW-1:0] add_acc(input logic [AW-1:0] a, input logic [DW-1:0] x,
                                            input logic [DW-1:0] w, input logic sat);
    logic signed [2*DW-1:0] xe, we, prod;
    logic [AW:0] s;
    xe = {{DW{x[DW-1]}}, x};
    we = {{DW{w[DW-1]}}, w};
    prod = xe * we;
    s = {a[AW-1], a} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
    if (sat && (s[AW] != s[AW-1])) add_acc = s[AW] ? ACC_MIN : ACC_MAX;
    else add_acc = s[AW-1:0];
  endfunction

  logic [ROWS-1:0] row_en;
  logic [COLS-1:0] col_en;
  logic            sat_en;
  logic [DW-1:0]   sh_w  [ROWS][COLS];
  logic [DW-1:0]   act_w [ROWS][COLS];
  logic [DW-1:0]   pe_x  [ROWS][COLS];
  logic [AW-1:0]   pe_p  [ROWS][COLS];
  logic [DW-1:0]   x_in  [ROWS][COLS];
  logic [AW-1:0]   p_in  [ROWS][COLS];
  logic [DW-1:0]   w_eff [ROWS][COLS];
  logic [AW-1:0]   pe_sum[ROWS][COLS];
  logic [DW-1:0]   row_x [ROWS];
  logic [AW-1:0]   col_acc[COLS];
  logic [AW-1:0]   col_out[COLS];
  logic [L:0]      v_q;
  logic [SW:1]     sw_q;
  logic [SW:0]     sw_d;
  logic [CW-1:0]   wr_cnt;
  logic            sw_now, row_ok, wr_ok, cfg_ok;

  // Weight port handshake: a row is written on an edge where w_valid && w_ready and no
  // switch is accepted on that same edge; every other w_valid edge is reported on w_drop.
  assign sw_now = in_valid & in_switch;
  assign sw_d   = {sw_q, sw_now};
  assign wr_ok  = w_valid & w_ready & ~sw_now & row_ok;
  assign cfg_ok = cfg_valid & ~busy & ~in_valid;
  assign busy      = |v_q;
  assign out_valid = v_q[L];

  if (ROWS == (1 << IW)) begin : g_idx_full
    assign row_ok = 1'b1;
  end else begin : g_idx_chk
    assign row_ok = (w_row_idx < IW'(ROWS));
  end

  assign row_x[0] = row_en[0] ? in_data[0] : '0;
  for (genvar r = 1; r < ROWS; r++) begin : g_row_skew
    logic [DW-1:0] sr [r];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < r; j++) sr[j] <= '0;
      end else begin
        sr[0] <= row_en[r] ? in_data[r] : '0;
        for (int j = 1; j < r; j++) sr[j] <= sr[j-1];
      end
    end
    assign row_x[r] = sr[r-1];
  end

  assign col_acc[0] = acc_in[0];
  for (genvar c = 1; c < COLS; c++) begin : g_acc_skew
    logic [AW-1:0] sa [c];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < c; j++) sa[j] <= '0;
      end else begin
        sa[0] <= acc_in[c];
        for (int j = 1; j < c; j++) sa[j] <= sa[j-1];
      end
    end
    assign col_acc[c] = sa[c-1];
  end

  // Column c leaves the array c cycles after column 0; pad it back into alignment.
  assign col_out[COLS-1] = pe_p[ROWS-1][COLS-1];
  for (genvar c = 0; c < COLS - 1; c++) begin : g_deskew
    logic [AW-1:0] sd [COLS-1-c];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < COLS - 1 - c; j++) sd[j] <= '0;
      end else begin
        sd[0] <= pe_p[ROWS-1][c];
        for (int j = 1; j < COLS - 1 - c; j++) sd[j] <= sd[j-1];
      end
    end
    assign col_out[c] = sd[COLS-2-c];
  end

  // A PE seeing its switch token computes with the shadow weight it is copying in.
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
    for (genvar c = 0; c < COLS; c++) begin : g_pe_c
      if (r == 0) begin : g_top
        assign p_in[r][c] = col_acc[c];
      end else begin : g_mid
        assign p_in[r][c] = pe_p[r-1][c];
      end
      if (c == 0) begin : g_left
        assign x_in[r][c] = row_x[r];
      end else begin : g_inner
        assign x_in[r][c] = pe_x[r][c-1];
      end
      assign w_eff[r][c]  = sw_d[r+c] ? sh_w[r][c] : act_w[r][c];
      assign pe_sum[r][c] = add_acc(p_in[r][c], x_in[r][c], w_eff[r][c], sat_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          sh_w[r][c]  <= '0;
          act_w[r][c] <= '0;
          pe_x[r][c]  <= '0;
          pe_p[r][c]  <= '0;
        end
      end
      v_q      <= '0;
      sw_q     <= '0;
      wr_cnt   <= '0;
      w_ready  <= 1'b1;
      w_drop   <= 1'b0;
      row_en   <= '1;
      col_en   <= '1;
      sat_en   <= 1'b0;
      cfg_err  <= 1'b0;
      out_data <= '0;
    end else begin
      v_q  <= {v_q[L-1:0], in_valid};
      sw_q <= sw_d[SW-1:0];
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          pe_x[r][c] <= x_in[r][c];
          pe_p[r][c] <= pe_sum[r][c];
          if (sw_d[r+c]) act_w[r][c] <= sh_w[r][c];
        end
      end
      if (wr_ok) begin
        for (int c = 0; c < COLS; c++) sh_w[w_row_idx][c] <= w_data[c];
      end
      w_drop <= w_valid & ~wr_ok;
      // Shadow stays locked until the switch wavefront has reached the last PE.
      if (sw_now) begin
        wr_cnt  <= CW'(SW);
        w_ready <= 1'b0;
      end else if (wr_cnt != '0) begin
        wr_cnt <= wr_cnt - 1'b1;
        if (wr_cnt == CW'(1)) w_ready <= 1'b1;
      end
      cfg_err <= cfg_valid & ~cfg_ok;
      if (cfg_ok) begin
        row_en <= cfg_row_en;
        col_en <= cfg_col_en;
        sat_en <= cfg_sat;
      end
      if (v_q[L-1]) begin
        for (int c = 0; c < COLS; c++) out_data[c] <= col_en[c] ? col_out[c] : '0;
      end
    end
  end
endmodule

// File: tb/tb_systolic_array_rect.sv
// Bench for systolic_array_rect (4x4): randomized and directed vectors, scoreboard queue
// filled from an arithmetic reference model, popped by an output monitor.
module tb_systolic_array_rect;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int L  = R + C - 1;
  localparam int OW = C * AW;
  localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_switch;
  logic [R-1:0][DW-1:0] in_data;
  logic [C-1:0][AW-1:0] acc_in;
  logic w_valid, w_ready;
  logic [IW-1:0] w_row_idx;
  logic [C-1:0][DW-1:0] w_data;
  logic w_drop, cfg_valid, cfg_sat, cfg_err, busy, out_valid;
  logic [R-1:0] cfg_row_en;
  logic [C-1:0] cfg_col_en;
  logic [C-1:0][AW-1:0] out_data;

  systolic_array_rect #(.ROWS(R), .COLS(C), .DATA_WIDTH_IN(DW), .DATA_WIDTH_ACCUM(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_switch(in_switch), .in_data(in_data),
    .acc_in(acc_in), .w_valid(w_valid), .w_ready(w_ready), .w_row_idx(w_row_idx),
    .w_data(w_data), .w_drop(w_drop), .cfg_valid(cfg_valid), .cfg_row_en(cfg_row_en),
    .cfg_col_en(cfg_col_en), .cfg_sat(cfg_sat), .cfg_err(cfg_err), .busy(busy),
    .out_valid(out_valid), .out_data(out_data)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];
  int due_q[$];

  // reference model state
  logic signed [DW-1:0] sh_m [R][C];
  logic signed [DW-1:0] act_m[R][C];
  logic [R-1:0] ren_m;
  logic [C-1:0] cen_m;
  logic sat_m;
  int ks, last_k;
  logic dir_en;
  logic [OW-1:0] dir_exp;

  task automatic chk(string name, logic [OW-1:0] got, logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h required %h", name, edge_n, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_out(logic [R-1:0][DW-1:0] x, logic [C-1:0][AW-1:0] a);
    logic [C-1:0][AW-1:0] y;
    longint s, p;
    for (int c = 0; c < C; c++) begin
      if (!cen_m[c]) y[c] = '0;
      else begin
        s = longint'($signed(a[c]));
        for (int r = 0; r < R; r++) begin
          p = ren_m[r] ? longint'($signed(x[r])) * longint'(act_m[r][c]) : 64'sd0;
          s = s + p;
          if (sat_m) begin
            if (s > MAXV) s = MAXV;
            else if (s < MINV) s = MINV;
          end else s = longint'($signed(s[AW-1:0]));
        end
        y[c] = s[AW-1:0];
      end
    end
    return y;
  endfunction

  task automatic idle_in();
    rst = 1'b0; in_valid = 1'b0; in_switch = 1'b0; in_data = '0; acc_in = '0;
    w_valid = 1'b0; w_row_idx = '0; w_data = '0; cfg_valid = 1'b0;
    cfg_row_en = '1; cfg_col_en = '1; cfg_sat = 1'b0; dir_en = 1'b0; dir_exp = '0;
  endtask

  // One clock: update the model with the inputs about to be sampled, then check flags.
  task automatic tick();
    int j;
    logic drop_e, err_e, cfg_ok, rdy, busy_b;
    j = edge_n + 1;
    drop_e = 1'b0;
    err_e = 1'b0;
    if (rst) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin sh_m[r][c] = '0; act_m[r][c] = '0; end
      ren_m = '1; cen_m = '1; sat_m = 1'b0; ks = -100; last_k = -100;
      exp_q.delete(); due_q.delete();
    end else begin
      rdy = !((j - 1 - ks) >= 0 && (j - 1 - ks) <= R + C - 3);
      busy_b = (j - 1 - last_k) <= L;
      if (w_valid) begin
        drop_e = !rdy || (in_valid && in_switch);
        if (!drop_e) for (int c = 0; c < C; c++) sh_m[w_row_idx][c] = w_data[c];
      end
      cfg_ok = cfg_valid && !in_valid && !busy_b;
      err_e = cfg_valid && !cfg_ok;
      if (in_valid) begin
        if (in_switch) begin act_m = sh_m; ks = j; end
        exp_q.push_back(dir_en ? dir_exp : ref_out(in_data, acc_in));
        due_q.push_back(j + L);
        last_k = j;
      end
      if (cfg_ok) begin ren_m = cfg_row_en; cen_m = cfg_col_en; sat_m = cfg_sat; end
    end
    @(posedge clk);
    #1;
    chk("w_drop", w_drop, drop_e);
    chk("cfg_err", cfg_err, err_e);
    chk("w_ready", w_ready, !((j - ks) >= 0 && (j - ks) <= R + C - 3));
    chk("busy", busy, (j - last_k) <= L);
    if (rst) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
    end
    idle_in();
  endtask

  // driver tasks
  task automatic wr_row(int idx, logic [C-1:0][DW-1:0] d);
    w_valid = 1'b1; w_row_idx = idx[IW-1:0]; w_data = d;
    tick();
  endtask

  task automatic load_fill(logic [DW-1:0] v);
    logic [C-1:0][DW-1:0] d;
    for (int c = 0; c < C; c++) d[c] = v;
    for (int r = 0; r < R; r++) wr_row(r, d);
  endtask

  task automatic load_identity();
    logic [C-1:0][DW-1:0] d;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) d[c] = (r == c) ? 8'd1 : 8'd0;
      wr_row(r, d);
    end
  endtask

  task automatic vec(logic [R-1:0][DW-1:0] x, logic [C-1:0][AW-1:0] a, logic sw);
    in_valid = 1'b1; in_switch = sw; in_data = x; acc_in = a;
    tick();
  endtask

  task automatic vec_exp(logic [R-1:0][DW-1:0] x, logic [C-1:0][AW-1:0] a, logic sw,
                         logic [OW-1:0] e);
    dir_en = 1'b1; dir_exp = e;
    vec(x, a, sw);
  endtask

  task automatic cfg(logic [R-1:0] re, logic [C-1:0] ce, logic s);
    cfg_valid = 1'b1; cfg_row_en = re; cfg_col_en = ce; cfg_sat = s;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin tick(); n++; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending outputs, required 0", exp_q.size());
      exp_q.delete(); due_q.delete();
    end
    tick(); tick();
  endtask

  function automatic logic [R-1:0][DW-1:0] rand_x();
    logic [R-1:0][DW-1:0] x;
    for (int r = 0; r < R; r++) x[r] = DW'($urandom_range(0, 255));
    return x;
  endfunction

  function automatic logic [C-1:0][AW-1:0] rand_acc();
    logic [C-1:0][AW-1:0] a;
    for (int c = 0; c < C; c++) a[c] = $urandom;
    return a;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected at edge %0d: got out_valid=1 data %h, required no output",
                 edge_n, out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
        chk("out_latency", edge_n, due_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R-1:0][DW-1:0] x;
    logic [C-1:0][AW-1:0] a;
    logic [C-1:0][AW-1:0] e;
    logic [C-1:0][DW-1:0] d;
    idle_in();
    rst = 1'b1; tick();
    rst = 1'b1; tick();

    // identity weights, switch on the first vector, three more back to back
    load_identity();
    for (int r = 0; r < R; r++) x[r] = DW'(r + 1);
    for (int c = 0; c < C; c++) e[c] = AW'(c + 1);
    vec_exp(x, '0, 1'b1, e);
    for (int i = 0; i < 3; i++) vec(rand_x(), rand_acc(), 1'b0);
    drain();

    // shadow of 2s switched in by the fourth vector of a burst
    load_fill(8'd2);
    for (int i = 0; i < 3; i++) vec(rand_x(), '0, 1'b0);
    for (int r = 0; r < R; r++) x[r] = 8'd1;
    for (int c = 0; c < C; c++) e[c] = 32'd8;
    vec_exp(x, '0, 1'b1, e);
    drain();

    // saturating vs wrapping accumulation
    load_fill(8'd127);
    cfg('1, '1, 1'b1);
    for (int r = 0; r < R; r++) x[r] = 8'd127;
    for (int c = 0; c < C; c++) begin a[c] = 32'd2147482647; e[c] = 32'h7FFF_FFFF; end
    vec_exp(x, a, 1'b1, e);
    drain();
    cfg('1, '1, 1'b0);
    for (int c = 0; c < C; c++) e[c] = 32'h8000_F81B;
    vec_exp(x, a, 1'b0, e);
    drain();

    // row/column masks, config rejected while busy
    load_identity();
    cfg(4'b1110, 4'b0011, 1'b0);
    for (int r = 0; r < R; r++) x[r] = DW'(r + 5);
    e = '0;
    e[1] = 32'd6;
    vec_exp(x, '0, 1'b1, e);
    cfg('1, '1, 1'b1);
    drain();
    vec_exp(x, '0, 1'b0, e);
    drain();
    cfg('1, '1, 1'b0);

    // write on the switch edge, writes inside the lock window, first write after it
    for (int c = 0; c < C; c++) d[c] = 8'd9;
    w_valid = 1'b1; w_row_idx = 2'd0; w_data = d;
    vec(rand_x(), '0, 1'b1);
    for (int i = 0; i < R + C - 2; i++) wr_row(1, d);
    for (int c = 0; c < C; c++) d[c] = 8'd3;
    wr_row(2, d);
    drain();
    for (int r = 0; r < R; r++) x[r] = 8'd1;
    for (int c = 0; c < C; c++) e[c] = (c == 2) ? 32'd3 : 32'd4;
    vec_exp(x, '0, 1'b1, e);
    drain();

    // randomized mix of vectors, switches, writes and config
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        in_valid = 1'b1; in_switch = ($urandom_range(0, 4) == 0);
        in_data = rand_x(); acc_in = rand_acc();
      end
      if ($urandom_range(0, 9) < 4) begin
        w_valid = 1'b1; w_row_idx = IW'($urandom_range(0, R - 1));
        for (int c = 0; c < C; c++) w_data[c] = DW'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 9) == 0 || (i % 30) == 29) begin
        cfg_valid = 1'b1; cfg_row_en = R'($urandom); cfg_col_en = C'($urandom);
        cfg_sat = 1'(($urandom));
      end
      if ((i % 30) == 29) in_valid = 1'b0;
      tick();
      if ((i % 30) == 28) begin
        for (int k = 0; k < L + 2; k++) tick();
      end
    end
    drain();

    // reset with three vectors in flight
    for (int r = 0; r < R; r++) wr_row(r, {$urandom});
    vec(rand_x(), rand_acc(), 1'b1);
    vec(rand_x(), rand_acc(), 1'b0);
    vec(rand_x(), rand_acc(), 1'b0);
    rst = 1'b1; tick();
    for (int i = 0; i < L + 3; i++) tick();
    a = rand_acc();
    vec_exp(rand_x(), a, 1'b1, a);
    drain();

    chk("queue_empty", exp_q.size(), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
